// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared types and helpers for the FFT frame controller.
//   state_t      - frame sequencer states
//   MIN_LOG2     - smallest legal FFT size exponent
//   NFFT_LSB, FWD_BIT, CFG_W, NFFT_W - config word layout
//   mk_cfg_word  - builds the core config word {7'b0, fwd, 3'b0, nfft_log2}
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CFG   = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int MIN_LOG2 = 3;

    localparam int NFFT_LSB = 0;
    localparam int NFFT_W   = 5;
    localparam int FWD_BIT  = 8;
    localparam int CFG_W    = 16;

    function automatic logic [CFG_W-1:0] mk_cfg_word(input logic [NFFT_W-1:0] log2,
                                                     input logic              fwd);
        logic [CFG_W-1:0] w;
        w                      = '0;
        w[NFFT_LSB +: NFFT_W]  = log2;
        w[FWD_BIT]             = fwd;
        return w;
    endfunction

endpackage

// File: rtl/fft_watchdog.sv
// fft_watchdog: idle-cycle watchdog for the result drain phase.
//   i_clk     - clock
//   i_rst     - synchronous active-high reset
//   i_load    - reload the counter to all-ones (a result beat, or not draining)
//   i_en      - count down this cycle
//   o_expire  - single-cycle pulse once 2^TIMEOUT_W-1 idle cycles have elapsed
// The counter holds the number of idle cycles still allowed; it expires while
// sitting at zero, i.e. the equivalent up-count of idle cycles is all-ones.
module fft_watchdog #(
    parameter int TIMEOUT_W = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    logic [TIMEOUT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '1;
        end else if (i_load) begin
            r_cnt <= '1;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A beat in the same cycle (load) beats the expiry.
    assign o_expire = i_en & ~i_load & (r_cnt == '0);

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: sequences one frame through a streaming FFT core.
//   ACLK, ARESET              - clock, synchronous active-high reset
//   start, abort              - control pulses from the register bank
//   cfg_nfft_log2, cfg_fwd    - frame size exponent and direction
//   m_cfg_*                   - config word channel to the core
//   s_src_*                   - sample buffer stream in
//   m_fft_*                   - core data stream out (passthrough, tlast generated)
//   res_tvalid/tready/tlast   - core result stream, monitored only
//   busy, done, err_*, aborted, frame_cnt - status back to the register bank
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int MAX_LOG2  = 10,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 20
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        cfg_nfft_log2,
    input  logic              cfg_fwd,
    output logic              m_cfg_tvalid,
    output logic [15:0]       m_cfg_tdata,
    input  logic              m_cfg_tready,
    input  logic              s_src_tvalid,
    input  logic [DATA_W-1:0] s_src_tdata,
    output logic              s_src_tready,
    output logic              m_fft_tvalid,
    output logic [DATA_W-1:0] m_fft_tdata,
    output logic              m_fft_tlast,
    input  logic              m_fft_tready,
    input  logic              res_tvalid,
    input  logic              res_tready,
    input  logic              res_tlast,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic              err_tlast,
    output logic              err_timeout,
    output logic              aborted,
    output logic [15:0]       frame_cnt
);

    localparam int CNT_W = MAX_LOG2 + 1;

    state_t              r_state, w_state_nxt;
    logic [NFFT_W-1:0]   r_log2;
    logic                r_fwd;
    logic [CNT_W-1:0]    r_in_cnt, r_out_cnt;
    logic                r_done, r_err_cfg, r_err_tlast, r_err_timeout, r_aborted;
    logic [15:0]         r_frame_cnt;

    logic [CNT_W-1:0]    w_n, w_nm1;
    logic                w_legal, w_res_beat, w_mon, w_out_last, w_last_in;
    logic                w_complete, w_expire, w_wd_load, w_draining;
    logic                w_start_ok, w_start_bad, w_cfg_hs, w_in_hs;
    logic                w_done_set, w_timeout, w_abort;

    assign w_n        = CNT_W'(1) << r_log2;
    assign w_nm1      = w_n - 1'b1;
    assign w_legal    = (cfg_nfft_log2 >= NFFT_W'(MIN_LOG2)) &&
                        (cfg_nfft_log2 <= NFFT_W'(MAX_LOG2));
    assign w_res_beat = res_tvalid & res_tready;
    assign w_mon      = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
    assign w_draining = (r_state == ST_DRAIN);
    assign w_out_last = (r_out_cnt == w_nm1);
    assign w_last_in  = (r_in_cnt == w_nm1);
    // out_cnt may already have saturated at N during LOAD.
    assign w_complete = w_draining && ((r_out_cnt == w_n) || (w_res_beat && w_out_last));
    assign w_wd_load  = ~w_draining | w_res_beat;

    fft_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_wd (
        .i_clk    (ACLK),
        .i_rst    (ARESET),
        .i_load   (w_wd_load),
        .i_en     (w_draining),
        .o_expire (w_expire)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        m_cfg_tvalid = 1'b0;
        m_cfg_tdata  = '0;
        m_fft_tvalid = 1'b0;
        m_fft_tdata  = '0;
        m_fft_tlast  = 1'b0;
        s_src_tready = 1'b0;
        w_start_ok   = 1'b0;
        w_start_bad  = 1'b0;
        w_cfg_hs     = 1'b0;
        w_in_hs      = 1'b0;
        w_done_set   = 1'b0;
        w_timeout    = 1'b0;
        w_abort      = abort && (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                // abort in the same cycle swallows the start
                if (start && !abort) begin
                    if (w_legal) begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = ST_CFG;
                    end else begin
                        w_start_bad = 1'b1;
                    end
                end
            end
            ST_CFG: begin
                m_cfg_tvalid = 1'b1;
                m_cfg_tdata  = mk_cfg_word(r_log2, r_fwd);
                if (m_cfg_tready) begin
                    w_cfg_hs    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                m_fft_tvalid = s_src_tvalid;
                s_src_tready = m_fft_tready;
                m_fft_tdata  = s_src_tdata;
                m_fft_tlast  = w_last_in;
                w_in_hs      = s_src_tvalid & m_fft_tready;
                if (w_in_hs && w_last_in) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_complete) begin
                    w_done_set  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Abort overrides any completion or timeout in the same cycle.
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_done_set  = 1'b0;
            w_timeout   = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_log2        <= '0;
            r_fwd         <= 1'b0;
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_done        <= 1'b0;
            r_err_cfg     <= 1'b0;
            r_err_tlast   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_aborted     <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            if (w_start_ok) begin
                r_log2        <= cfg_nfft_log2;
                r_fwd         <= cfg_fwd;
                r_done        <= 1'b0;
                r_err_cfg     <= 1'b0;
                r_err_tlast   <= 1'b0;
                r_err_timeout <= 1'b0;
                r_aborted     <= 1'b0;
            end
            if (w_start_bad) begin
                r_err_cfg <= 1'b1;
                r_done    <= 1'b0;
            end
            if (w_cfg_hs) begin
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
            end
            if (w_in_hs) r_in_cnt <= r_in_cnt + 1'b1;
            if (w_mon && w_res_beat) begin
                if (r_out_cnt != w_n) r_out_cnt <= r_out_cnt + 1'b1;
                // tlast must appear on beat N-1 and nowhere else
                if (res_tlast != w_out_last) r_err_tlast <= 1'b1;
            end
            if (w_done_set) begin
                r_done      <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_timeout) r_err_timeout <= 1'b1;
            if (w_abort)   r_aborted     <= 1'b1;
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign err_cfg     = r_err_cfg;
    assign err_tlast   = r_err_tlast;
    assign err_timeout = r_err_timeout;
    assign aborted     = r_aborted;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed bench for fft_frame_ctrl (TIMEOUT_W=4).
module tb_fft_frame_ctrl;

    localparam int DW = 32;

    logic          ACLK = 1'b0;
    logic          ARESET, start, abort, cfg_fwd;
    logic [4:0]    cfg_nfft_log2;
    logic          m_cfg_tvalid, m_cfg_tready;
    logic [15:0]   m_cfg_tdata;
    logic          s_src_tvalid, s_src_tready;
    logic [DW-1:0] s_src_tdata, m_fft_tdata;
    logic          m_fft_tvalid, m_fft_tlast, m_fft_tready;
    logic          res_tvalid, res_tready, res_tlast;
    logic          busy, done, err_cfg, err_tlast, err_timeout, aborted;
    logic [15:0]   frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ACLK = ~ACLK;

    fft_frame_ctrl #(.MAX_LOG2(10), .DATA_W(DW), .TIMEOUT_W(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
        .cfg_nfft_log2(cfg_nfft_log2), .cfg_fwd(cfg_fwd),
        .m_cfg_tvalid(m_cfg_tvalid), .m_cfg_tdata(m_cfg_tdata), .m_cfg_tready(m_cfg_tready),
        .s_src_tvalid(s_src_tvalid), .s_src_tdata(s_src_tdata), .s_src_tready(s_src_tready),
        .m_fft_tvalid(m_fft_tvalid), .m_fft_tdata(m_fft_tdata), .m_fft_tlast(m_fft_tlast),
        .m_fft_tready(m_fft_tready),
        .res_tvalid(res_tvalid), .res_tready(res_tready), .res_tlast(res_tlast),
        .busy(busy), .done(done), .err_cfg(err_cfg), .err_tlast(err_tlast),
        .err_timeout(err_timeout), .aborted(aborted), .frame_cnt(frame_cnt)
    );

    task automatic nxt();
        @(posedge ACLK); #1;
    endtask

    task automatic do_start(input logic [4:0] l2, input logic fwd);
        cfg_nfft_log2 = l2; cfg_fwd = fwd; start = 1'b1;
        nxt();
        start = 1'b0; #1;
    endtask

    task automatic cfg_hs();
        m_cfg_tready = 1'b1;
        nxt();
        m_cfg_tready = 1'b0; #1;
    endtask

    // Drives samples base+k; stops after max_beats handshakes or at the tlast beat.
    task automatic feed(input int max_beats, input bit rnd, input logic [31:0] base,
                        output int beats, output int bad, output int last_at, output int last_cnt);
        bit hs, lst;
        beats = 0; bad = 0; last_at = -1; last_cnt = 0;
        for (int c = 0; c < 500 && beats < max_beats; c++) begin
            s_src_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_fft_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_src_tdata  = base + 32'(beats);
            #1;
            hs  = m_fft_tvalid && m_fft_tready;
            lst = m_fft_tlast;
            if (hs) begin
                if (m_fft_tdata !== base + 32'(beats)) bad++;
                if (lst) begin
                    last_cnt++;
                    if (last_at < 0) last_at = beats;
                end
                beats++;
            end
            nxt();
            if (hs && lst) break;
        end
        s_src_tvalid = 1'b0; m_fft_tready = 1'b1; #1;
    endtask

    task automatic results(input int first, input int last, input int tl_beat);
        for (int b = first; b < last; b++) begin
            res_tvalid = 1'b1; res_tready = 1'b1; res_tlast = (b == tl_beat);
            nxt();
        end
        res_tvalid = 1'b0; res_tready = 1'b0; res_tlast = 1'b0; #1;
    endtask

    task automatic test_reset();
        ARESET = 1'b1; start = 0; abort = 0; cfg_nfft_log2 = 0; cfg_fwd = 0;
        m_cfg_tready = 0; s_src_tvalid = 0; s_src_tdata = 0; m_fft_tready = 1'b1;
        res_tvalid = 0; res_tready = 0; res_tlast = 0;
        repeat (3) nxt();
        ARESET = 1'b0; #1;
        n_tests++; if ({busy, done, err_cfg, err_tlast, err_timeout, aborted, m_cfg_tvalid, m_fft_tvalid, m_fft_tlast, s_src_tready} !== 10'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0", {busy, done, err_cfg, err_tlast, err_timeout, aborted, m_cfg_tvalid, m_fft_tvalid, m_fft_tlast, s_src_tready}); end
        n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        n_tests++; if (m_cfg_tdata !== 16'h0) begin n_fail++; $display("FAIL reset_cfg_tdata: got %h expected 0000", m_cfg_tdata); end
    endtask

    task automatic test_frame();
        int b, bad, la, lc;
        do_start(5'd3, 1'b1);
        n_tests++; if ({busy, m_cfg_tvalid} !== 2'b11) begin n_fail++; $display("FAIL frame_cfg_valid: got %b expected 11", {busy, m_cfg_tvalid}); end
        n_tests++; if (m_cfg_tdata !== 16'h0103) begin n_fail++; $display("FAIL frame_cfg_word: got %h expected 0103", m_cfg_tdata); end
        nxt();
        n_tests++; if ({m_cfg_tvalid, m_cfg_tdata} !== {1'b1, 16'h0103}) begin n_fail++; $display("FAIL frame_cfg_hold: got %b/%h expected 1/0103", m_cfg_tvalid, m_cfg_tdata); end
        cfg_hs();
        n_tests++; if (m_cfg_tvalid !== 1'b0) begin n_fail++; $display("FAIL frame_cfg_drop: got %b expected 0", m_cfg_tvalid); end
        feed(8, 1'b0, 32'hA000, b, bad, la, lc);
        n_tests++; if (b !== 8 || bad !== 0) begin n_fail++; $display("FAIL frame_beats: got %0d beats %0d bad expected 8/0", b, bad); end
        n_tests++; if (la !== 7 || lc !== 1) begin n_fail++; $display("FAIL frame_tlast: got at %0d count %0d expected 7/1", la, lc); end
        s_src_tvalid = 1'b1; #1;
        n_tests++; if ({m_fft_tvalid, s_src_tready, busy, done} !== 4'b0010) begin n_fail++; $display("FAIL frame_drain_gate: got %b expected 0010", {m_fft_tvalid, s_src_tready, busy, done}); end
        s_src_tvalid = 1'b0;
        results(0, 8, 7);
        n_tests++; if ({busy, done} !== 2'b01 || frame_cnt !== 16'd1) begin n_fail++; $display("FAIL frame_done: got busy/done %b cnt %0d expected 01/1", {busy, done}, frame_cnt); end
        n_tests++; if ({err_cfg, err_tlast, err_timeout, aborted} !== 4'b0) begin n_fail++; $display("FAIL frame_errs: got %b expected 0000", {err_cfg, err_tlast, err_timeout, aborted}); end
    endtask

    task automatic test_backpressure();
        int b, bad, la, lc;
        do_start(5'd4, 1'b0);
        n_tests++; if (m_cfg_tdata !== 16'h0004) begin n_fail++; $display("FAIL bp_cfg_word: got %h expected 0004", m_cfg_tdata); end
        cfg_hs();
        feed(16, 1'b1, 32'hB000, b, bad, la, lc);
        n_tests++; if (b !== 16 || bad !== 0) begin n_fail++; $display("FAIL bp_beats: got %0d beats %0d bad expected 16/0", b, bad); end
        n_tests++; if (la !== 15 || lc !== 1) begin n_fail++; $display("FAIL bp_tlast: got at %0d count %0d expected 15/1", la, lc); end
        results(0, 16, 15);
        n_tests++; if ({done, err_tlast} !== 2'b10 || frame_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_done: got done/err %b cnt %0d expected 10/2", {done, err_tlast}, frame_cnt); end
    endtask

    task automatic test_illegal();
        bit seen = 1'b0;
        do_start(5'd2, 1'b1);
        n_tests++; if ({err_cfg, busy, m_cfg_tvalid, done} !== 4'b1000) begin n_fail++; $display("FAIL illegal_lo: got %b expected 1000", {err_cfg, busy, m_cfg_tvalid, done}); end
        repeat (3) begin nxt(); if (m_cfg_tvalid || busy) seen = 1'b1; end
        do_start(5'd11, 1'b1);
        n_tests++; if ({err_cfg, busy, m_cfg_tvalid} !== 3'b100) begin n_fail++; $display("FAIL illegal_hi: got %b expected 100", {err_cfg, busy, m_cfg_tvalid}); end
        repeat (3) begin nxt(); if (m_cfg_tvalid || busy) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL illegal_no_cfg: got %b expected 0", seen); end
        do_start(5'd10, 1'b1);
        n_tests++; if ({busy, err_cfg} !== 2'b10 || m_cfg_tdata !== 16'h010A) begin n_fail++; $display("FAIL legal_max: got %b/%h expected 10/010A", {busy, err_cfg}, m_cfg_tdata); end
        abort = 1'b1; nxt(); abort = 1'b0; #1;
        n_tests++; if ({busy, aborted, m_cfg_tvalid} !== 3'b010) begin n_fail++; $display("FAIL abort_cfg: got %b expected 010", {busy, aborted, m_cfg_tvalid}); end
    endtask

    task automatic test_tlast_err();
        int b, bad, la, lc;
        do_start(5'd3, 1'b1);
        n_tests++; if ({err_cfg, aborted} !== 2'b00) begin n_fail++; $display("FAIL start_clears: got %b expected 00", {err_cfg, aborted}); end
        cfg_hs();
        feed(8, 1'b0, 32'hC000, b, bad, la, lc);
        results(0, 6, 5);
        n_tests++; if ({err_tlast, done, busy} !== 3'b101) begin n_fail++; $display("FAIL tlast_early: got %b expected 101", {err_tlast, done, busy}); end
        results(6, 8, 5);
        n_tests++; if ({done, busy} !== 2'b10 || frame_cnt !== 16'd3) begin n_fail++; $display("FAIL tlast_early_done: got %b cnt %0d expected 10/3", {done, busy}, frame_cnt); end
        do_start(5'd3, 1'b0);
        n_tests++; if ({err_tlast, done} !== 2'b00) begin n_fail++; $display("FAIL tlast_cleared: got %b expected 00", {err_tlast, done}); end
        cfg_hs();
        feed(8, 1'b0, 32'hD000, b, bad, la, lc);
        results(0, 8, -1);
        n_tests++; if ({err_tlast, done} !== 2'b11 || frame_cnt !== 16'd4) begin n_fail++; $display("FAIL tlast_missing: got %b cnt %0d expected 11/4", {err_tlast, done}, frame_cnt); end
    endtask

    task automatic test_watchdog();
        int b, bad, la, lc;
        int k = 0;
        do_start(5'd3, 1'b1);
        cfg_hs();
        feed(8, 1'b0, 32'hE000, b, bad, la, lc);
        results(0, 3, -1);
        while (busy && k < 40) begin nxt(); k++; end
        n_tests++; if (k !== 16) begin n_fail++; $display("FAIL wd_latency: got %0d cycles expected 16", k); end
        n_tests++; if ({busy, err_timeout, done} !== 3'b010 || frame_cnt !== 16'd4) begin n_fail++; $display("FAIL wd_state: got %b cnt %0d expected 010/4", {busy, err_timeout, done}, frame_cnt); end
    endtask

    task automatic test_abort();
        int b, bad, la, lc;
        do_start(5'd3, 1'b1);
        cfg_hs();
        feed(4, 1'b0, 32'hF000, b, bad, la, lc);
        n_tests++; if (b !== 4 || la !== -1) begin n_fail++; $display("FAIL abort_prefix: got %0d beats last %0d expected 4/-1", b, la); end
        s_src_tvalid = 1'b1; m_fft_tready = 1'b1; abort = 1'b1; #1;
        n_tests++; if (s_src_tready !== 1'b1) begin n_fail++; $display("FAIL abort_same_cycle: got %b expected 1", s_src_tready); end
        nxt(); abort = 1'b0; #1;
        n_tests++; if ({busy, aborted, s_src_tready, m_fft_tvalid, done} !== 5'b01000 || frame_cnt !== 16'd4) begin n_fail++; $display("FAIL abort_next: got %b cnt %0d expected 01000/4", {busy, aborted, s_src_tready, m_fft_tvalid, done}, frame_cnt); end
        s_src_tvalid = 1'b0;
        cfg_nfft_log2 = 5'd3; start = 1'b1; abort = 1'b1;
        nxt(); start = 1'b0; abort = 1'b0; #1;
        n_tests++; if ({busy, m_cfg_tvalid, aborted} !== 3'b001) begin n_fail++; $display("FAIL start_abort: got %b expected 001", {busy, m_cfg_tvalid, aborted}); end
    endtask

    task automatic test_reset_drain();
        int b, bad, la, lc;
        do_start(5'd3, 1'b1);
        cfg_hs();
        feed(8, 1'b0, 32'h1000, b, bad, la, lc);
        results(0, 2, -1);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
        ARESET = 1'b1; nxt(); ARESET = 1'b0; #1;
        n_tests++; if ({busy, done, err_cfg, err_tlast, err_timeout, aborted, m_cfg_tvalid, m_fft_tvalid, s_src_tready} !== 9'b0 || frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drain: got %b cnt %0d expected 0/0", {busy, done, err_cfg, err_tlast, err_timeout, aborted, m_cfg_tvalid, m_fft_tvalid, s_src_tready}, frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_illegal();
        test_tlast_err();
        test_watchdog();
        test_abort();
        test_reset_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
